// File: rtl/peg_draw_scheduler.sv
// peg_draw_scheduler: shares one VGA pixel-plot path between the guess-peg
// renderer (A) and the feedback-peg renderer (B). A granted request names a
// square (top-left corner, size class, colour). The square is walked row-major,
// one registered pixel per clock, and its requester gets a one-cycle ack.
// Optional build macro: SCREEN_CLEAR_EN adds a full-screen clear request that
// outranks A and B.
//
// state | meaning
// IDLE  | waiting for a request; round-robin arbitration happens here
// DRAW  | walking the granted square, one pixel per clock
// CLEAR | walking every screen pixel with colour 0 (SCREEN_CLEAR_EN only)
// DONE  | one-cycle ack to whoever was served; requests are not sampled
module peg_draw_scheduler #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int COLOUR_W = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_a,
  input  logic [8:0]          base_x_a,
  input  logic [7:0]          base_y_a,
  input  logic [1:0]          size_a,
  input  logic [COLOUR_W-1:0] colour_a,
  input  logic                req_b,
  input  logic [8:0]          base_x_b,
  input  logic [7:0]          base_y_b,
  input  logic [1:0]          size_b,
  input  logic [COLOUR_W-1:0] colour_b,
`ifdef SCREEN_CLEAR_EN
  input  logic                clear_req,
  output logic                clear_ack,
`endif
  output logic                ack_a,
  output logic                ack_b,
  output logic                busy,
  output logic                plot,
  output logic [8:0]          x_out,
  output logic [7:0]          y_out,
  output logic [COLOUR_W-1:0] colour_out
);

`ifdef SCREEN_CLEAR_EN
  localparam int IDX_W = 17;
  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE, S_CLEAR} state_t;
  localparam logic [IDX_W-1:0] CLR_LAST = IDX_W'(SCREEN_W * SCREEN_H - 1);
  localparam logic [8:0]       X_MAX    = 9'(SCREEN_W - 1);
  localparam logic [1:0]       SRV_CLR  = 2'd2;
`else
  localparam int IDX_W = 9;
  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;
`endif
  localparam logic [1:0] SRV_A = 2'd0;
  localparam logic [1:0] SRV_B = 2'd1;
  // Coordinate sums are one bit wider than the buses so clipping never sees a wrap.
  localparam logic [9:0] X_LIM = 10'(SCREEN_W);
  localparam logic [8:0] Y_LIM = 9'(SCREEN_H);

  state_t             state, nxt_state;
  logic               last_grant, nxt_last;   // 1 = B was served last
  logic [1:0]         serve, nxt_serve;
  logic [8:0]         bx_r, nxt_bx;
  logic [7:0]         by_r, nxt_by;
  logic [1:0]         size_r, nxt_size;
  logic [IDX_W-1:0]   idx, nxt_idx;
  logic [8:0]         ox, nxt_ox;
  logic [7:0]         oy, nxt_oy;
  logic               nxt_plot, nxt_ack_a, nxt_ack_b, nxt_busy;
  logic [8:0]         nxt_x;
  logic [7:0]         nxt_y;
  logic [COLOUR_W-1:0] nxt_col;
  logic               pick_b, emit;
  logic [4:0]         side_m1;
  logic [IDX_W-1:0]   last_idx;
  logic [9:0]         x_sum;
  logic [8:0]         y_sum;
`ifdef SCREEN_CLEAR_EN
  logic               nxt_clr_ack;
`endif

  // Square geometry for the latched size class.
  always_comb begin
    side_m1  = 5'd3;
    last_idx = IDX_W'(15);
    case (size_r)
      2'b01:   begin side_m1 = 5'd9;  last_idx = IDX_W'(99);  end
      2'b10:   begin side_m1 = 5'd19; last_idx = IDX_W'(399); end
      default: ;
    endcase
  end

  // Next-state, pixel walk and registered-output preparation.
  always_comb begin
    nxt_state = state;
    nxt_last  = last_grant;
    nxt_serve = serve;
    nxt_bx    = bx_r;
    nxt_by    = by_r;
    nxt_size  = size_r;
    nxt_idx   = idx;
    nxt_ox    = ox;
    nxt_oy    = oy;
    nxt_col   = colour_out;
    emit      = 1'b0;
    pick_b    = 1'b0;
    case (state)
      S_IDLE: begin
`ifdef SCREEN_CLEAR_EN
        if (clear_req) begin
          nxt_state = S_CLEAR;
          nxt_serve = SRV_CLR;
          nxt_bx    = '0;
          nxt_by    = '0;
          nxt_idx   = '0;
          nxt_ox    = '0;
          nxt_oy    = '0;
          nxt_col   = '0;
          emit      = 1'b1;
        end else
`endif
        if (req_a || req_b) begin
          // On a tie the requester not served last time wins.
          pick_b    = req_b && (!req_a || !last_grant);
          nxt_last  = pick_b;
          nxt_serve = pick_b ? SRV_B : SRV_A;
          nxt_bx    = pick_b ? base_x_b : base_x_a;
          nxt_by    = pick_b ? base_y_b : base_y_a;
          nxt_size  = pick_b ? size_b : size_a;
          nxt_col   = pick_b ? colour_b : colour_a;
          nxt_idx   = '0;
          nxt_ox    = '0;
          nxt_oy    = '0;
          if (nxt_size == 2'b11) begin
            nxt_state = S_DONE;
          end else begin
            nxt_state = S_DRAW;
            emit      = 1'b1;
          end
        end
      end
      S_DRAW: begin
        if (idx == last_idx) begin
          nxt_state = S_DONE;
        end else begin
          nxt_idx = idx + IDX_W'(1);
          if (ox == {4'd0, side_m1}) begin
            nxt_ox = '0;
            nxt_oy = oy + 8'd1;
          end else begin
            nxt_ox = ox + 9'd1;
          end
          emit = 1'b1;
        end
      end
`ifdef SCREEN_CLEAR_EN
      S_CLEAR: begin
        if (idx == CLR_LAST) begin
          nxt_state = S_DONE;
        end else begin
          nxt_idx = idx + IDX_W'(1);
          if (ox == X_MAX) begin
            nxt_ox = '0;
            nxt_oy = oy + 8'd1;
          end else begin
            nxt_ox = ox + 9'd1;
          end
          emit = 1'b1;
        end
      end
`endif
      S_DONE:  nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
    x_sum     = {1'b0, nxt_bx} + {1'b0, nxt_ox};
    y_sum     = {1'b0, nxt_by} + {1'b0, nxt_oy};
    nxt_plot  = emit && (x_sum < X_LIM) && (y_sum < Y_LIM);
    nxt_x     = emit ? x_sum[8:0] : x_out;
    nxt_y     = emit ? y_sum[7:0] : y_out;
    nxt_ack_a = (nxt_state == S_DONE) && (nxt_serve == SRV_A);
    nxt_ack_b = (nxt_state == S_DONE) && (nxt_serve == SRV_B);
    nxt_busy  = (nxt_state != S_IDLE);
`ifdef SCREEN_CLEAR_EN
    nxt_clr_ack = (nxt_state == S_DONE) && (nxt_serve == SRV_CLR);
`endif
  end

  // State and registered outputs; reset aborts any draw without an ack.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      serve      <= SRV_A;
      bx_r       <= '0;
      by_r       <= '0;
      size_r     <= '0;
      idx        <= '0;
      ox         <= '0;
      oy         <= '0;
      plot       <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      busy       <= 1'b0;
`ifdef SCREEN_CLEAR_EN
      clear_ack  <= 1'b0;
`endif
    end else begin
      state      <= nxt_state;
      last_grant <= nxt_last;
      serve      <= nxt_serve;
      bx_r       <= nxt_bx;
      by_r       <= nxt_by;
      size_r     <= nxt_size;
      idx        <= nxt_idx;
      ox         <= nxt_ox;
      oy         <= nxt_oy;
      plot       <= nxt_plot;
      x_out      <= nxt_x;
      y_out      <= nxt_y;
      colour_out <= nxt_col;
      ack_a      <= nxt_ack_a;
      ack_b      <= nxt_ack_b;
      busy       <= nxt_busy;
`ifdef SCREEN_CLEAR_EN
      clear_ack  <= nxt_clr_ack;
`endif
    end
  end

endmodule
